gmii_rx_parser: RTL

//  Consumes a GMII receive stream (rxd/rx_dv) such as the one produced by gmii_driver.

---
 rtl/gmii_rx_parser_if.sv | 20 ++
 rtl/gmii_rx_parser.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_parser_if.sv
// Output byte stream of the GMII receive parser.
// srdy/drdy handshake carrying a frame byte plus SOP/EOP/error markers.
interface gmii_rx_parser_if;
  logic       p_srdy;
  logic       p_drdy;
  logic [7:0] p_data;
  logic       p_sop;
  logic       p_eop;
  logic       p_err;

  modport master (
    output p_srdy, p_data, p_sop, p_eop, p_err,
    input  p_drdy
  );

  modport slave (
    input  p_srdy, p_data, p_sop, p_eop, p_err,
    output p_drdy
  );
endinterface

// File: rtl/gmii_rx_parser.sv
// GMII receive parser: strips preamble/SFD, checks and strips FCS,
// buffers frame bytes in a show-ahead FIFO for a stallable consumer.
module gmii_rx_parser #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             rx_clk,
  input  logic             reset_n,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  gmii_rx_parser_if.master p,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] crc_err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  PRE_B   = 8'h55;
  localparam logic [7:0]  SFD_B   = 8'hD5;
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    S_IDLE, S_PRE, S_DATA, S_DROP
  } state_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       err;
    logic [7:0] data;
  } ent_t;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       crc_q, crc_d;
  logic [3:0][7:0]   sh_q, sh_d;
  logic [2:0]        shn_q, shn_d;
  logic [7:0]        pend_q, pend_d;
  logic              pv_q, pv_d;
  logic              sop_q, sop_d;
  logic              ovf_q, ovf_d;
  logic              hv_q, hv_d;
  ent_t              hold_q, hold_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;

  ent_t              mem_q [FIFO_DEPTH];
  logic [AW:0]       wp_q, rp_q;
  logic              empty, full, rd, can_wr;
  logic              we, wr_en;
  ent_t              wdat, head;
  logic              sfd, acc, fin, crc_bad;

  assign empty  = (wp_q == rp_q);
  assign full   = ((wp_q ^ rp_q) == {1'b1, {AW{1'b0}}});
  assign rd     = ~empty & p.p_drdy;
  // A read on the same edge frees the slot a full-FIFO write needs.
  assign can_wr = ~full | rd;
  assign wr_en  = we & can_wr;
  assign head   = mem_q[rp_q[AW-1:0]];

  assign p.p_srdy = ~empty;
  assign p.p_data = empty ? 8'h00 : head.data;
  assign p.p_sop  = ~empty & head.sop;
  assign p.p_eop  = ~empty & head.eop;
  assign p.p_err  = ~empty & head.err;

  assign frame_cnt   = fcnt_q;
  assign crc_err_cnt = ecnt_q;
  assign drop_cnt    = dcnt_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    shn_d   = shn_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    sop_d   = sop_q;
    ovf_d   = ovf_q;
    hv_d    = hv_q;
    hold_d  = hold_q;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    dcnt_d  = dcnt_q;
    we      = 1'b0;
    wdat    = '0;
    sfd     = 1'b0;
    acc     = 1'b0;
    fin     = 1'b0;
    crc_bad = (crc_q != RESIDUE);

    if (hv_q && can_wr) begin
      we   = 1'b1;
      wdat = hold_q;
      hv_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: if (rx_dv) begin
        if (hv_q) begin
          state_d = S_DROP;
          dcnt_d  = dcnt_q + CNT_W'(1);
        end else if (rxd == PRE_B) begin
          state_d = S_PRE;
        end else if (rxd == SFD_B) begin
          state_d = S_DATA;
          sfd     = 1'b1;
        end else begin
          state_d = S_DROP;
          dcnt_d  = dcnt_q + CNT_W'(1);
        end
      end
      S_PRE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
          dcnt_d  = dcnt_q + CNT_W'(1);
        end else if (rxd == SFD_B) begin
          state_d = S_DATA;
          sfd     = 1'b1;
        end else if (rxd != PRE_B) begin
          state_d = S_DROP;
          dcnt_d  = dcnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (rx_dv) begin
          acc = 1'b1;
        end else begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: if (!rx_dv) state_d = S_IDLE;
    endcase

    if (sfd) begin
      crc_d = 32'hFFFFFFFF;
      shn_d = 3'd0;
      pv_d  = 1'b0;
      sop_d = 1'b1;
      ovf_d = 1'b0;
    end

    // The last four bytes seen are held back until they prove not to be FCS.
    if (acc) begin
      crc_d = crc_upd(crc_q, rxd);
      if (pv_q) begin
        we   = 1'b1;
        wdat = '{sop: sop_q, eop: 1'b0, err: 1'b0, data: pend_q};
        if (can_wr) sop_d = 1'b0;
        else        ovf_d = 1'b1;
      end
      if (shn_q == 3'd4) begin
        pend_d = sh_q[3];
        pv_d   = 1'b1;
      end else begin
        shn_d = shn_q + 3'd1;
      end
      sh_d = {sh_q[2:0], rxd};
    end

    if (fin) begin
      if (pv_q) begin
        we   = 1'b1;
        wdat = '{sop: sop_q, eop: 1'b1, err: crc_bad | ovf_q, data: pend_q};
        if (!can_wr) begin
          hv_d   = 1'b1;
          hold_d = wdat;
        end
        fcnt_d = fcnt_q + CNT_W'(1);
        if (crc_bad) ecnt_d = ecnt_q + CNT_W'(1);
      end else begin
        dcnt_d = dcnt_q + CNT_W'(1);
      end
      pv_d = 1'b0;
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      crc_q   <= '0;
      sh_q    <= '0;
      shn_q   <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      sop_q   <= 1'b0;
      ovf_q   <= 1'b0;
      hv_q    <= 1'b0;
      hold_q  <= '0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
      dcnt_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      sh_q    <= sh_d;
      shn_q   <= shn_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      sop_q   <= sop_d;
      ovf_q   <= ovf_d;
      hv_q    <= hv_d;
      hold_q  <= hold_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
      dcnt_q  <= dcnt_d;
      if (wr_en) wp_q <= wp_q + (AW+1)'(1);
      if (rd)    rp_q <= rp_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge rx_clk) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= wdat;
  end

endmodule
